hdmi_pixel_unpacker: RTL
========================

# hdmi_pixel_unpacker

Read-side consumer of the DDR3 frame-buffer prefetch FIFO in the OV5640-to-HDMI path. Pops 32-bit words with a valid/ready handshake, splits each into two RGB565 pixels, expands them to RGB888 and aligns them with the HDMI timing generator's sync/DE.
- Flags and counts underflows: DE active with no word available.
- Refuses to emit pixels until the first frame boundary after reset.

## Interface
Parameters:
- c_WORD_WIDTH, 32, FIFO word width; fixed at 2 × 16-bit pixels, other values illegal.
- c_UF_CNT_WIDTH, 16, width of the saturating underflow counter.

Ports:
- rd_clk  in  1  pixel clock, shared with the FIFO read side.
- rd_rst  in  1  reset rd_rst, asynchronous, active-high; clock rd_clk.
- fifo_data  in  32  FIFO read data; valid whenever fifo_vld=1. Pixel 0 = [15:0], pixel 1 = [31:16].
- fifo_vld  in  1  FIFO word available.
- fifo_rd_en  out  1  pop strobe; a word is consumed when fifo_rd_en & fifo_vld.
- vs_in, hs_in, de_in  in  1 each  timing-generator outputs, rd_clk domain, active-high.
- vs_out, hs_out, de_out  out  1 each  timing delayed by 1 cycle.
- rgb_out  out  24  {R8,G8,B8}, aligned with de_out.
- frame_start  out  1  one-cycle pulse, aligned with the vs_out rising edge.
- underflow  out  1  sticky flag, cleared per frame.
- underflow_cnt  out  c_UF_CNT_WIDTH  total missed words since reset; saturating.

## Operation
State machine:
- IDLE (reset state): fifo_rd_en=0; de_in ignored; rgb_out=0; timing is still passed through delayed.
- IDLE → RUN on a vs_in rising edge (vs_in=1 and vs_in_d=0).
- RUN stays until reset; there is no other exit.

Phase bit `ph` (RUN only):
- Cleared in IDLE and on every cycle with de_in=0.
- Toggles on every cycle with de_in=1.
- H_ACTIVE is therefore assumed even; an odd line leaves the last upper half unused, and the next line restarts at ph=0.

Handshake (combinational):
- fifo_rd_en = RUN & de_in & ~ph.
- Never asserted when de_in=0 or ph=1.

Cycle with de_in=1, ph=0:
- If fifo_vld=1: emit fifo_data[15:0]; latch fifo_data[31:16] into hi_reg; set hi_ok=1.
- If fifo_vld=0: emit black (0x000000); hi_ok=0; set underflow=1; increment underflow_cnt unless it is all-ones.

Cycle with de_in=1, ph=1:
- Emit hi_reg if hi_ok=1, otherwise black.
- No pop occurs. A half-word miss is not counted separately; one miss is counted per word.

Colour expansion:
- R8 = {r5, r5[4:2]}, G8 = {g6, g6[5:4]}, B8 = {b5, b5[4:2]}.
- RGB565 layout is [15:11]=R, [10:5]=G, [4:0]=B.

Blanking:
- rgb_out = 0 whenever the registered de_out=0.

Frame boundary:
- A vs_in rising edge in RUN pulses frame_start and clears underflow.
- A simultaneous underflow event in the same cycle wins: underflow is set.

Reset:
- Mid-frame reset forces IDLE and drops any latched half-word.
- The FIFO is not flushed by this block.

## Timing
- Reset values: fifo_rd_en=0, vs_out=hs_out=de_out=0, rgb_out=0, frame_start=0, underflow=0, underflow_cnt=0, ph=0, hi_ok=0.
- Latency: 1 cycle from vs_in/hs_in/de_in to vs_out/hs_out/de_out. rgb_out is registered in the same stage.
- Pop timing: fifo_rd_en is asserted in the same cycle as de_in. The upstream FIFO presents data with zero latency (show-ahead), so the word sampled is fifo_data in that cycle.
- Maximum pop rate: one word per 2 active cycles. A new pop never occurs in consecutive cycles.
- First emitted pixel: the first de_in=1 cycle after the vs_in rise that entered RUN.
- frame_start appears 1 cycle after the vs_in rise, coincident with the vs_out rise.
- underflow_cnt saturates at 2^c_UF_CNT_WIDTH − 1.

## Test plan
- Reset, then de_in pulses with no vs_in, fifo_vld=1 → fifo_rd_en stays 0, rgb_out=0, no words consumed.
- vs_in edge, then a 4-cycle DE line with words 0xFFFF_F800, 0x001F_07E0 → pops on DE cycles 0 and 2; rgb_out = 0xFF0000 (red), 0xFFFFFF (white), 0x00FF00 (green), 0x0000FF (blue), each 1 cycle after its DE cycle. de_out is aligned with these pixels.
- fifo_vld=0 on DE cycle 0 of a line → two black pixels, underflow=1, underflow_cnt=1. The next vs_in rise clears underflow while the count stays 1.
- 5-cycle (odd) DE line followed by a new line → the second line's first pixel is from a freshly popped word[15:0]; 3 pops are made for the 5-cycle line.
- Force underflow_cnt to all-ones (c_UF_CNT_WIDTH=4, 16 misses) → the counter holds at 15.
- Assert rd_rst mid-line → all outputs 0 immediately; pixel output resumes only after the next vs_in rising edge.

Source files
------------

// File: rtl/hdmi_pixel_unpacker.sv
// Pops packed RGB565 pixel pairs from the frame-buffer prefetch FIFO, expands them to RGB888
// and aligns them with the HDMI timing. Pixels are withheld until the first vsync after reset.
module hdmi_pixel_unpacker #(
  parameter int c_WORD_WIDTH   = 32,
  parameter int c_UF_CNT_WIDTH = 16
) (
  input  logic                      rd_clk,
  input  logic                      rd_rst,
  input  logic [c_WORD_WIDTH-1:0]   fifo_data,
  input  logic                      fifo_vld,
  output logic                      fifo_rd_en,
  input  logic                      vs_in,
  input  logic                      hs_in,
  input  logic                      de_in,
  output logic                      vs_out,
  output logic                      hs_out,
  output logic                      de_out,
  output logic [23:0]               rgb_out,
  output logic                      frame_start,
  output logic                      underflow,
  output logic [c_UF_CNT_WIDTH-1:0] underflow_cnt
);

  // state | meaning
  // IDLE  | waiting for the first vsync rise; no pops, black pixels, timing still delayed
  // RUN   | unpacking words on active video; left only by reset
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam int c_HALF = c_WORD_WIDTH / 2;

  logic [0:0]                state_q, state_d;
  logic                      vs_q, vs_d;
  logic                      hs_q, hs_d;
  logic                      de_q, de_d;
  logic [23:0]               rgb_q, rgb_d;
  logic                      frame_start_q, frame_start_d;
  logic                      underflow_q, underflow_d;
  logic [c_UF_CNT_WIDTH-1:0] uf_cnt_q, uf_cnt_d;
  logic                      ph_q, ph_d;
  logic                      hi_ok_q, hi_ok_d;
  logic [c_HALF-1:0]         hi_reg_q, hi_reg_d;
  logic                      vs_rise;
  logic                      uf_evt;

  function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

  assign vs_rise    = vs_in & ~vs_q;
  assign fifo_rd_en = (state_q == S_RUN) & de_in & ~ph_q;

  always_comb begin
    state_d       = state_q;
    vs_d          = vs_in;
    hs_d          = hs_in;
    de_d          = de_in;
    rgb_d         = 24'h000000;
    frame_start_d = vs_rise;
    ph_d          = 1'b0;
    hi_ok_d       = hi_ok_q;
    hi_reg_d      = hi_reg_q;
    uf_evt        = 1'b0;

    if (state_q == S_IDLE) begin
      hi_ok_d = 1'b0;
      if (vs_rise) state_d = S_RUN;
    end else if (de_in) begin
      ph_d = ~ph_q;
      if (!ph_q) begin
        if (fifo_vld) begin
          rgb_d    = rgb565_to_888(fifo_data[c_HALF-1:0]);
          hi_reg_d = fifo_data[c_WORD_WIDTH-1:c_HALF];
          hi_ok_d  = 1'b1;
        end else begin
          hi_ok_d = 1'b0;
          uf_evt  = 1'b1;
        end
      end else if (hi_ok_q) begin
        rgb_d = rgb565_to_888(hi_reg_q);
      end
    end

    // a miss in the vsync cycle must survive the per-frame clear
    if (uf_evt)       underflow_d = 1'b1;
    else if (vs_rise) underflow_d = 1'b0;
    else              underflow_d = underflow_q;

    if (uf_evt && (uf_cnt_q != {c_UF_CNT_WIDTH{1'b1}}))
      uf_cnt_d = uf_cnt_q + {{(c_UF_CNT_WIDTH-1){1'b0}}, 1'b1};
    else
      uf_cnt_d = uf_cnt_q;
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q       <= S_IDLE;
      vs_q          <= 1'b0;
      hs_q          <= 1'b0;
      de_q          <= 1'b0;
      rgb_q         <= 24'h000000;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
      uf_cnt_q      <= '0;
      ph_q          <= 1'b0;
      hi_ok_q       <= 1'b0;
      hi_reg_q      <= '0;
    end else begin
      state_q       <= state_d;
      vs_q          <= vs_d;
      hs_q          <= hs_d;
      de_q          <= de_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
      uf_cnt_q      <= uf_cnt_d;
      ph_q          <= ph_d;
      hi_ok_q       <= hi_ok_d;
      hi_reg_q      <= hi_reg_d;
    end
  end

  assign vs_out        = vs_q;
  assign hs_out        = hs_q;
  assign de_out        = de_q;
  assign rgb_out       = de_q ? rgb_q : 24'h000000;
  assign frame_start   = frame_start_q;
  assign underflow     = underflow_q;
  assign underflow_cnt = uf_cnt_q;

endmodule
